// File: rtl/sync_fifo_param.sv
// Single-clock parameterised FIFO with registered read data and sticky overflow/underflow flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; the default build uses 1-cycle read latency.
module sync_fifo_param #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 7,
  parameter int AFULL_LVL  = (2**ADDR_W) - 4,
  parameter int AEMPTY_LVL = 4
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              clr,
  input  logic              wrtEn,
  input  logic [DATA_W-1:0] wrtData,
  input  logic              rdEn,
  output logic [DATA_W-1:0] rdData,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_LVL);
  localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_LVL);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   mem_cnt;
  logic              wr_acc;
  logic              rd_acc;

  assign mem_cnt      = wr_ptr - rd_ptr;
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);
  assign wr_acc       = wrtEn && !full;

  always_ff @(posedge clk) begin
    if (wr_acc && !clr) begin
      mem[wr_ptr[ADDR_W-1:0]] <= wrtData;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow  | (wrtEn & full);
      underflow <= underflow | (rdEn & empty);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // rdData acts as an output stage holding the head word; count includes it.
  logic out_valid;
  logic load;
  logic mem_empty;

  assign count     = mem_cnt + {{ADDR_W{1'b0}}, out_valid};
  assign empty     = !out_valid;
  assign rd_acc    = rdEn && out_valid;
  assign mem_empty = (mem_cnt == '0);
  assign load      = !out_valid || rd_acc;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      rdData    <= '0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      rdData    <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (load) begin
        if (!mem_empty) begin
          rdData    <= mem[rd_ptr[ADDR_W-1:0]];
          rd_ptr    <= rd_ptr + PTR_ONE;
          out_valid <= 1'b1;
        end else if (wr_acc) begin
          // Bypass: the word lands in the array and is consumed from it in the same edge.
          rdData    <= wrtData;
          rd_ptr    <= rd_ptr + PTR_ONE;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end
`else
  assign count  = mem_cnt;
  assign empty  = (mem_cnt == '0);
  assign rd_acc = rdEn && !empty;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rdData <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rdData <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rdData <= mem[rd_ptr[ADDR_W-1:0]];
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised scoreboard bench for sync_fifo_param (DEPTH=8); a queue model predicts flags and read data.
module tb_sync_fifo_param;
  localparam int DEPTH = 8;
  localparam int AFL   = 6;
  localparam int AEL   = 2;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       clr = 1'b0;
  logic       wrtEn = 1'b0;
  logic       rdEn = 1'b0;
  logic [7:0] wrtData = 8'h00;
  logic [7:0] rdData;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  int errors = 0;
  int checks = 0;

  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  bit         ov_m = 1'b0;
  bit         un_m = 1'b0;
  bit         fire = 1'b0;
  logic [7:0] hold_val = 8'h00;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_W(8), .ADDR_W(3), .AFULL_LVL(AFL), .AEMPTY_LVL(AEL)
  ) dut (
    .clk(clk), .rst_(rst_), .clr(clr), .wrtEn(wrtEn), .wrtData(wrtData),
    .rdEn(rdEn), .rdData(rdData), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status();
    int n;
    n = model_q.size();
    chk("count", count, n);
    chk("full", full, (n == DEPTH));
    chk("empty", empty, (n == 0));
    chk("almost_full", almost_full, (n >= AFL));
    chk("almost_empty", almost_empty, (n <= AEL));
    chk("overflow", overflow, ov_m);
    chk("underflow", underflow, un_m);
  endtask

  // One clock of stimulus: check state from previous edges, drive, update model.
  task automatic cyc(input bit we, input bit re, input bit c, input logic [7:0] d);
    int n;
    logic [7:0] popped;
    bit racc;
    @(negedge clk);
    check_status();
    wrtEn = we; rdEn = re; clr = c; wrtData = d;
    racc = 1'b0;
    popped = 8'h00;
    if (c) begin
      model_q.delete();
      ov_m = 1'b0;
      un_m = 1'b0;
    end else begin
      n = model_q.size();
      if (we && n == DEPTH) ov_m = 1'b1;
      if (re && n == 0) un_m = 1'b1;
      if (re && n != 0) begin
        racc = 1'b1;
        popped = model_q.pop_front();
      end
      if (we && n != DEPTH) model_q.push_back(d);
    end
`ifdef SYNC_FIFO_FWFT_EN
    if (c) begin
      exp_q.push_back(8'h00); fire = 1'b1;
    end else if (model_q.size() > 0) begin
      exp_q.push_back(model_q[0]); fire = 1'b1;
    end else begin
      fire = 1'b0;
    end
`else
    if (c) begin
      exp_q.push_back(8'h00); fire = 1'b1;
    end else if (racc) begin
      exp_q.push_back(popped); fire = 1'b1;
    end else begin
      fire = 1'b0;
    end
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_ = 1'b0; fire = 1'b0;
    wrtEn = 1'b0; rdEn = 1'b0; clr = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rddata", rdData, 0);
    chk("rst_aempty", almost_empty, 1);
    model_q.delete();
    ov_m = 1'b0;
    un_m = 1'b0;
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  // Monitor: compare rdData after each edge against the scoreboard.
  initial begin
    bit f;
    logic [7:0] e;
    forever begin
      @(posedge clk);
      f = fire;
      #1;
      if (!rst_) begin
        hold_val = 8'h00;
        exp_q.delete();
        continue;
      end
      if (f) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rd_queue: no expected word queued at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          checks--;
          chk("rd_data", rdData, e);
          hold_val = e;
        end
      end
`ifndef SYNC_FIFO_FWFT_EN
      else begin
        chk("rd_hold", rdData, hold_val);
      end
`endif
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("init_count", count, 0);
    chk("init_empty", empty, 1);
    chk("init_rddata", rdData, 0);
    chk("init_full", full, 0);
    chk("init_afull", almost_full, 0);
    rst_ = 1'b1;

    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 8'(8'h10 + i));
    cyc(1, 0, 0, 8'h99);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
    chk("drain_hold_17", rdData, 8'h17);
`endif
    cyc(0, 0, 1, 8'h00);

    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 8'(8'h30 + i));
    for (int i = 0; i < 20; i++) cyc(1, 1, 0, 8'(8'h40 + i));
    cyc(0, 0, 0, 8'h00);
    chk("wrap_count", count, 3);

    cyc(1, 0, 0, 8'h55);
    cyc(1, 0, 0, 8'h56);
    cyc(1, 1, 1, 8'h57);
    cyc(0, 0, 0, 8'h00);
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);

    cyc(1, 0, 0, 8'hA5);
    cyc(0, 0, 0, 8'h00);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_a5", rdData, 8'hA5);
`endif
    cyc(0, 1, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      cyc(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45),
          ($urandom_range(0, 59) == 0), 8'($urandom));
    end
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    @(negedge clk);
    if (exp_q.size() > 1) begin
      checks++;
      errors++;
      $display("FAIL rd_leftover: %0d words never presented", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter ADDR_W, default 7, log2 of depth; DEPTH = 2**ADDR_W words (ADDR_W >= 2).
REQ-003 SHALL have parameter AFULL_LVL, default DEPTH-4, almost_full threshold in words (1..DEPTH-1).
REQ-004 SHALL have parameter AEMPTY_LVL, default 4, almost_empty threshold in words (1..DEPTH-1).
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all logic on the rising edge
- rst_  in  1  reset, asynchronous assert, active-low
- clr  in  1  synchronous flush
- wrtEn  in  1  write request
- wrtData  in  DATA_W  write data
- rdEn  in  1  read/pop request
- rdData  out  DATA_W  read data, registered
- full  out  1  count == DEPTH
- empty  out  1  no readable word
- almost_full  out  1  count >= AFULL_LVL
- almost_empty  out  1  count <= AEMPTY_LVL
- count  out  ADDR_W+1  words stored
- overflow  out  1  sticky, write attempted while full
- underflow  out  1  sticky, read attempted while empty

Function
REQ-006 SHALL hold words in a DEPTH x DATA_W array, with ADDR_W+1-bit write/read pointers; the MSB is the wrap bit and the low ADDR_W bits the address.
REQ-007 SHALL accept a write iff wrtEn=1 and full=0: store wrtData at the write address, then write pointer +1 modulo 2**(ADDR_W+1).
REQ-008 SHALL accept a read iff rdEn=1 and empty=0: read pointer +1 modulo 2**(ADDR_W+1).
REQ-009 SHALL, on simultaneous accepted read and write, perform both in the same cycle, leaving count unchanged.
REQ-010 SHALL reject a write while full, even if a read is accepted the same cycle; a read while empty is always rejected.
REQ-011 SHALL keep count equal to accepted writes minus accepted reads since the last reset/clr (range 0..DEPTH); all status flags are derived combinationally from registered state.
REQ-012 SHALL set overflow on wrtEn=1 with full=1 and underflow on rdEn=1 with empty=1, visible the next cycle; both hold until clr or reset.
REQ-013 SHALL, on clr=1, zero both pointers, count, overflow, underflow and rdData next cycle; clr overrides wrtEn/rdEn that cycle; array contents are don't-care.
REQ-014 SHALL wrap pointers past DEPTH with no data loss or flag glitch; full and empty are never both 1.

Reset
REQ-015 SHALL, while rst_=0, asynchronously force pointers=0, count=0, rdData=0, overflow=0, underflow=0, so empty=1, almost_empty=1, full=0, almost_full=0.
REQ-016 SHALL discard all stored data on reset mid-operation and resume accepting writes on the first rising clk after rst_ deasserts.

Configuration
REQ-017 SHALL use macro SYNC_FIFO_FWFT_EN to select read mode.
REQ-018 Without SYNC_FIFO_FWFT_EN: rdData SHALL load the head word on the edge that accepts a read (1-cycle latency) and hold otherwise; empty = (count == 0).
REQ-019 With SYNC_FIFO_FWFT_EN: rdData SHALL present the head word whenever empty=0, without rdEn; rdEn pops it and the next word (if any) SHALL appear the following cycle.
REQ-020 With SYNC_FIFO_FWFT_EN: a write into an empty FIFO SHALL clear empty one cycle later; count includes the word in the output stage; total capacity stays DEPTH.

Verification (ADDR_W=3, DEPTH=8, AFULL_LVL=6, AEMPTY_LVL=2, DATA_W=8)
REQ-021 Reset: assert rst_=0 mid-stream -> count=0, empty=1, rdData=0x00 with no clk edge needed.
REQ-022 Fill: write 0x10..0x17 -> almost_full=1 at count 6, full=1 at count 8; a 9th write -> data dropped, overflow=1, count stays 8.
REQ-023 Drain (standard): read 8 times -> rdData 0x10..0x17, one cycle after each rdEn; then a further rdEn -> underflow=1, rdData holds 0x17.
REQ-024 Wrap: 20 cycles of simultaneous write/read at count=3 -> count stays 3, output order matches input order across pointer wrap.
REQ-025 Flush: clr=1 with wrtEn=1 and rdEn=1 at count=5 -> next cycle count=0, empty=1, overflow=0, underflow=0.
REQ-026 FWFT build: write 0xA5 into empty -> next cycle empty=0, rdData=0xA5 with rdEn=0; rdEn=1 -> empty=1 next cycle.
